// File: rtl/mux_sched_pkg.sv
// Shared types and constants for the two-lane byte scheduler.
// FSM state encoding, default byte width, lane indices, state helper.
package mux_sched_pkg;

  localparam int DATA_W = 8;

  localparam logic LANE0 = 1'b0;
  localparam logic LANE1 = 1'b1;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    SERVE0 = 2'b01,
    SERVE1 = 2'b10
  } state_t;

  function automatic state_t serve_of(input logic lane);
    return lane ? SERVE1 : SERVE0;
  endfunction

endpackage

// File: rtl/lane_fifo.sv
// Per-lane synchronous FIFO with show-ahead head and occupancy count.
// Ports: clk, rst_n, push, pop, din -> dout, full, empty, count.
module lane_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty,
  output logic [AW:0]  count
);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + (AW+1)'(do_push)
                     - (AW+1)'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/mux_lane_scheduler.sv
// Round-robin burst scheduler of two byte lanes onto one registered stream.
// Ports: clk_2f, reset_L, data/valid/ready_0/1, pause -> data/valid/lane_out, err_0/1.
module mux_lane_scheduler #(
  parameter int DATA_W     = mux_sched_pkg::DATA_W,
  parameter int FIFO_DEPTH = 4,
  parameter int MAX_BURST  = 4
) (
  input  logic              clk_2f,
  input  logic              reset_L,
  input  logic [DATA_W-1:0] data_0,
  input  logic              valid_0,
  output logic              ready_0,
  input  logic [DATA_W-1:0] data_1,
  input  logic              valid_1,
  output logic              ready_1,
  input  logic              pause,
  output logic [DATA_W-1:0] data_out,
  output logic              valid_out,
  output logic              lane_out,
  output logic              err_0,
  output logic              err_1
);
  import mux_sched_pkg::*;

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int BW = $clog2(MAX_BURST + 1);

  logic              push0, push1;
  logic              pop0, pop1;
  logic              full0, full1;
  logic              empty0, empty1;
  logic [AW:0]       cnt0, cnt1;
  logic [DATA_W-1:0] head0, head1;

  state_t        state_q, state_d;
  logic          last_q, last_d;
  logic [BW-1:0] bcnt_q, bcnt_d;

  logic          cur;
  logic          cur_empty, oth_empty;
  logic          cur_push;
  logic [AW:0]   cur_cnt;

  assign ready_0 = reset_L & ~full0;
  assign ready_1 = reset_L & ~full1;
  assign push0   = valid_0 & ready_0;
  assign push1   = valid_1 & ready_1;

  lane_fifo #(.W(DATA_W), .DEPTH(FIFO_DEPTH)) u_fifo0 (
    .clk(clk_2f), .rst_n(reset_L),
    .push(push0), .pop(pop0), .din(data_0),
    .dout(head0), .full(full0), .empty(empty0),
    .count(cnt0)
  );

  lane_fifo #(.W(DATA_W), .DEPTH(FIFO_DEPTH)) u_fifo1 (
    .clk(clk_2f), .rst_n(reset_L),
    .push(push1), .pop(pop1), .din(data_1),
    .dout(head1), .full(full1), .empty(empty1),
    .count(cnt1)
  );

  assign cur       = (state_q == SERVE1);
  assign cur_empty = cur ? empty1 : empty0;
  assign oth_empty = cur ? empty0 : empty1;
  assign cur_push  = cur ? push1 : push0;
  assign cur_cnt   = cur ? cnt1 : cnt0;

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    bcnt_d  = bcnt_q;
    pop0    = 1'b0;
    pop1    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!empty0 && !empty1) begin
          state_d = serve_of(~last_q);
          last_d  = ~last_q;
        end else if (!empty0) begin
          state_d = SERVE0;
          last_d  = LANE0;
        end else if (!empty1) begin
          state_d = SERVE1;
          last_d  = LANE1;
        end
        bcnt_d = '0;
      end
      SERVE0, SERVE1: begin
        if (!pause && cur_empty) begin
          state_d = IDLE;
        end else if (!pause) begin
          pop0 = ~cur;
          pop1 = cur;
          if (cur_cnt == (AW+1)'(1) && !cur_push) begin
            // Lane drained: hand over or fall back to idle
            state_d = oth_empty ? IDLE : serve_of(~cur);
            last_d  = oth_empty ? last_q : ~cur;
            bcnt_d  = '0;
          end else if (bcnt_q == BW'(MAX_BURST - 1)) begin
            // Burst budget spent; keep serving only if nobody waits
            if (!oth_empty) begin
              state_d = serve_of(~cur);
              last_d  = ~cur;
            end
            bcnt_d = '0;
          end else begin
            bcnt_d = bcnt_q + BW'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_2f or negedge reset_L) begin
    if (!reset_L) begin
      state_q <= IDLE;
      last_q  <= LANE1;
      bcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      bcnt_q  <= bcnt_d;
    end
  end

  always_ff @(posedge clk_2f or negedge reset_L) begin
    if (!reset_L) begin
      data_out  <= '0;
      valid_out <= 1'b0;
      lane_out  <= LANE0;
      err_0     <= 1'b0;
      err_1     <= 1'b0;
    end else begin
      valid_out <= pop0 | pop1;
      if (pop0 | pop1) begin
        data_out <= pop1 ? head1 : head0;
        lane_out <= pop1 ? LANE1 : LANE0;
      end
      if (valid_0 && full0) err_0 <= 1'b1;
      if (valid_1 && full1) err_1 <= 1'b1;
    end
  end

endmodule

// File: doc/mux_lane_scheduler.md
# mux_lane_scheduler

Round-robin scheduler that shares the single serialized byte lane of the physical layer between two byte-stream requesters (lane 0, lane 1). Each lane's bytes are buffered in a small FIFO. A three-state arbiter drains the FIFOs in bounded bursts onto one registered output stream tagged with its source lane, honouring a downstream pause. It sits in front of the lane serializer and replaces the free-running clock-phase selection with demand-driven, fair sequencing.

## Interface
- DATA_W, 8, byte width of every data port
- FIFO_DEPTH, 4, entries per lane FIFO (power of two, ≥2)
- MAX_BURST, 4, max consecutive pops from one lane while the other lane is waiting (≥1)

- clk_2f  in  1  single clock; all state updates on rising edge
- reset_L  in  1  asynchronous, active-low reset
- data_0  in  DATA_W  lane 0 write byte
- valid_0  in  1  lane 0 write strobe
- ready_0  out  1  lane 0 FIFO can accept (0 while reset_L=0, else ~full_0)
- data_1  in  DATA_W  lane 1 write byte
- valid_1  in  1  lane 1 write strobe
- ready_1  out  1  lane 1 FIFO can accept (same rule)
- pause  in  1  downstream stall; no pop while high
- data_out  out  DATA_W  scheduled byte (registered)
- valid_out  out  1  data_out valid this cycle (registered)
- lane_out  out  1  source lane of data_out (registered)
- err_0  out  1  sticky: lane 0 write dropped while full
- err_1  out  1  sticky: lane 1 write dropped while full

## Operation
- Write: valid_x & ready_x pushes data_x. valid_x while full drops the byte and sets err_x. ready_x uses the current full flag, so a simultaneous pop does not make room in the same cycle. err_x clears only on reset.
- A write and a pop on the same non-full FIFO in one cycle are both performed.
- State machine states: IDLE, SERVE0, SERVE1. A last_grant bit is reset to 1, so lane 0 wins first. burst_cnt is sized for 0..MAX_BURST.
- IDLE: if both FIFOs are non-empty, go to SERVE of the lane ≠ last_grant. If one is non-empty, go to SERVE of that lane. Otherwise stay. No pop in IDLE. On entry to SERVEx: last_grant ← x, burst_cnt ← 0.
- SERVEx with pause=0 and FIFO x non-empty: pop; next edge data_out ← head, lane_out ← x, valid_out ← 1; burst_cnt+1.
- SERVEx with pause=1: no pop; valid_out ← 0; state, burst_cnt and data_out are held.
- Leaving SERVEx, evaluated on each pop:
  - If the pop empties FIFO x (count==1, no same-cycle write): go to SERVE(other) if other is non-empty, else IDLE.
  - Else if burst_cnt+1 == MAX_BURST and other is non-empty: go directly to SERVE(other).
  - Else if burst_cnt+1 == MAX_BURST and other is empty: stay and reset burst_cnt to 0.
- Any cycle without a pop: valid_out ← 0; data_out and lane_out keep their last value.

## Timing
- Reset values: data_out=0, valid_out=0, lane_out=0, err_0=err_1=0, ready_0=ready_1=0 while asserted. FIFOs empty, state IDLE, last_grant=1, burst_cnt=0.
- Reset mid-operation: all buffered bytes are discarded immediately (async). The first write is accepted on the first edge after deassertion.
- Latency from an idle block: byte written at edge k → IDLE→SERVE at edge k+1 → valid_out=1 after edge k+2.
- Back-to-back throughput: 1 byte/cycle while the served FIFO stays non-empty and pause=0.
- Lane switch via SERVEx→SERVEy costs no bubble. Switch via IDLE costs one bubble cycle.
- pause asserted at edge k: no pop at k; valid_out=0 after k. Resume is immediate on the first edge with pause=0.
- Full boundary: FIFO_DEPTH accepted writes → ready_x=0 after that edge.

## Structure
- Shared package mux_sched_pkg holds:
  - state encoding constants IDLE=2'b00, SERVE0=2'b01, SERVE1=2'b10
  - DATA_W default
  - lane index constants LANE0=0, LANE1=1
- Sub-module lane_fifo: synchronous FIFO with ports push, pop, din, dout (show-ahead head), full, empty, count. It uses the same clock and asynchronous reset and is instantiated twice.
- The arbiter FSM, burst counter and output register live in the top module.

## Test plan
- Lane 0 only: write 0x11,0x22,0x33 on consecutive cycles, pause=0 → valid_out bytes 0x11,0x22,0x33 with lane_out=0, first one two edges after the first write; then IDLE.
- Both FIFOs preloaded with 4 bytes each (0xA0–A3, 0xB0–B3), MAX_BURST=2 → output A0,A1,B0,B1,A2,A3,B2,B3, with no bubble between bursts.
- Overflow: 5 writes to lane 1 with pause=1 → ready_1=0 after the 4th, the 5th byte is dropped, err_1=1; releasing pause yields exactly 4 bytes.
- Pause mid-stream: pause high for 3 cycles during a lane 0 burst → valid_out=0 for exactly 3 cycles, then the next byte in order with no loss or duplication.
- Reset mid-burst: assert reset_L=0 with 3 bytes queued → all outputs return to reset values asynchronously. After release, a new write 0x5A emerges alone on lane 0.
- Simultaneous first requests from both lanes out of reset → lane 0 is served first.
